sbox_layer_dec: RTL and testbench
=================================

// Module: sbox_layer_dec
// PURPOSE
//  Iterative inverse S-box layer of the PRESENT decryption datapath. Sits directly
//  downstream of the inverse permutation stage and consumes its 64-bit permuted
//  state. Substitutes NPC nibbles per clock through the PRESENT inverse S-box.
//  Hands the result to the next round stage over a valid/ready handshake.
// PARAMETERS
//  SIZE  64  state width in bits; fixed to `size, which must be 64
//  NPC   4   nibbles substituted per cycle; legal values 1, 2, 4, 8, 16
//            (elaboration error otherwise)
// PORTS
//  Clock      in   1     single clock; all state updates on its rising edge
//  Reset_n    in   1     asynchronous, active-low reset
//  in_valid   in   1     upstream state word is valid
//  in_ready   out  1     block can accept a word (high only in IDLE)
//  in_data    in   SIZE  state from the inverse permutation stage
//  out_valid  out  1     out_data holds a finished word
//  out_ready  in   1     downstream accepts out_data
//  out_data   out  SIZE  substituted state
//  busy       out  1     high in RUN and DONE
// BEHAVIOUR
//  Reset (asynchronous, Reset_n low):
//   - state = IDLE; work reg = 0; cnt = 0
//   - in_ready = 1; out_valid = 0; busy = 0; out_data = 0
//  Inverse S-box table, input 0..F -> 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
//  Register widths:
//   - cnt is clog2(16/NPC) bits, minimum 1 bit
//   - out_data is driven directly from the work register
//  FSM:
//   - IDLE: in_ready = 1. When in_valid && in_ready: work <= in_data, cnt <= 0,
//     go to RUN.
//   - RUN: in_ready = 0. Each cycle, nibbles [cnt*NPC .. cnt*NPC+NPC-1] are
//     replaced in place (nibble 0 = bits 3:0). cnt increments by 1.
//     After the chunk with cnt == 16/NPC-1, go to DONE.
//   - DONE: out_valid = 1; out_data is stable and does not change while
//     out_valid && !out_ready. When out_ready is high: go to IDLE, out_valid
//     falls on that edge.
//  Latency: out_valid rises on the 16/NPC-th rising edge after the accepting
//  edge (4 edges for NPC = 4; 1 edge for NPC = 16).
//  Throughput: one word per 16/NPC + 2 cycles. No accept is possible in the
//  cycle out_valid falls, because in_ready only rises in IDLE.
//  Boundary conditions:
//   - in_valid outside IDLE: ignored; upstream must hold the word.
//   - in_data changes during RUN: no effect; the word was captured at accept.
//   - out_ready high while not in DONE: ignored.
//   - Reset_n low in any state: immediate abort to reset values; the partial
//     word is discarded and never presented.
//   - cnt never wraps inside RUN; it is cleared on every accept.
// CONFIGURATION
//  SBOX_LAYER_FWD_EN defined:
//   - Adds input port "inverse" (1 bit), sampled on the accepting edge and held
//     for the whole word.
//   - inverse = 0 selects the forward PRESENT S-box:
//     0..F -> C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
//   - inverse = 1 selects the inverse table.
//  SBOX_LAYER_FWD_EN undefined: no "inverse" port; inverse table only.
//  No other difference in timing or behaviour.
// TESTING
//  1. Reset check: hold Reset_n low -> in_ready = 1, out_valid = 0, busy = 0,
//     out_data = 0.
//  2. Single word, NPC = 4: in_data = 0x0123456789ABCDEF, out_ready = 1 ->
//     out_valid rises 4 edges after accept, out_data = 0x5EF8C12DB463079A.
//  3. Backpressure: in_data = 0x0000000000000000, out_ready held 0 for 10 cycles
//     -> out_valid and out_data = 0x5555555555555555 stay stable; in_ready = 0
//     throughout; when out_ready = 1, IDLE on the next edge.
//  4. Mid-operation reset: pulse Reset_n low during the 2nd RUN cycle -> all
//     outputs return to reset values; no out_valid. Then accept
//     0xFFFFFFFFFFFFFFFF -> 0xAAAAAAAAAAAAAAAA.
//  5. NPC sweep 1/2/8/16: with 0x0123456789ABCDEF, latency is 16/8/2/1 edges;
//     result is identical.
//  6. SBOX_LAYER_FWD_EN with inverse = 0, in_data = 0x0 -> out_data =
//     0xCCCCCCCCCCCCCCCC. Feeding that back with inverse = 1 -> 0x0.

Source files
------------

// File: rtl/sbox_layer_dec.sv
// sbox_layer_dec -- iterative inverse S-box layer of the PRESENT decryption
// datapath. Accepts a 64-bit state word from the inverse permutation stage,
// substitutes NPC nibbles per clock in place, and then presents the result
// over a valid/ready handshake.
//
// Optional feature macro: SBOX_LAYER_FWD_EN
//   When defined, an extra "inverse" input selects the forward (0) or
//   inverse (1) PRESENT S-box. It is sampled when a word is accepted.
//   When undefined, only the inverse table exists.
//
// Ports
//   inverse   in   1     table select (only with SBOX_LAYER_FWD_EN)
//   Clock     in   1     rising-edge clock
//   Reset_n   in   1     asynchronous active-low reset
//   in_valid  in   1     upstream word valid
//   in_ready  out  1     high only in IDLE
//   in_data   in   SIZE  permuted state word
//   out_valid out  1     out_data holds a finished word (DONE)
//   out_ready in   1     downstream accepts out_data
//   out_data  out  SIZE  substituted state, driven from the work register
//   busy      out  1     high in RUN and DONE
module sbox_layer_dec #(
    parameter int SIZE = 64,
    parameter int NPC  = 4
) (
`ifdef SBOX_LAYER_FWD_EN
    input  logic            inverse,
`endif
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            busy
);
    localparam int STEPS = 16 / NPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CHUNK = 4 * NPC;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (SIZE != 64) begin : g_bad_size
            $error("sbox_layer_dec: SIZE must be 64");
        end
        if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
            $error("sbox_layer_dec: NPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SIZE-1:0]        work;
    logic [CW-1:0]          cnt;
    logic                   inv_q;
    logic [NPC-1:0][3:0]    lane_in, lane_out;

    wire accept = in_valid && (state == IDLE);

    // Table select (1 = inverse). Held for the whole word.
`ifdef SBOX_LAYER_FWD_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)    inv_q <= 1'b1;
        else if (accept) inv_q <= inverse;
    end
`else
    assign inv_q = 1'b1;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x, input logic inv);
        logic [3:0] y;
        y = 4'h0;
        if (inv) begin
            case (x)
                4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
                4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
                4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
                4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
            endcase
        end else begin
            case (x)
                4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
                4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
                4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
                4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
            endcase
        end
        return y;
    endfunction

    // Current chunk: nibbles cnt*NPC .. cnt*NPC+NPC-1.
    always_comb lane_in = work[int'(cnt)*CHUNK +: CHUNK];

    generate
        for (genvar g = 0; g < NPC; g++) begin : g_lane
            always_comb lane_out[g] = sbox(lane_in[g], inv_q);
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = RUN;
            RUN:     if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            work <= in_data;
            cnt  <= '0;
        end else if (state == RUN) begin
            work[int'(cnt)*CHUNK +: CHUNK] <= lane_out;
            // Hold at the last chunk rather than wrapping; the next accept clears it.
            if (cnt != LAST) cnt <= cnt + 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

endmodule

// File: tb/tb_sbox_layer_dec.sv
module tb_sbox_layer_dec;
    localparam int NI = 5;  // instance i uses NPC = 1 << i

    localparam logic [3:0] INV_T [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                          4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
    localparam logic [3:0] FWD_T [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic                    Clock = 1'b0;
    logic                    Reset_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [63:0]             in_data = '0;
    logic                    out_ready = 1'b1;
    logic                    inverse = 1'b1;
    logic [NI-1:0]           in_ready, out_valid, busy;
    logic [NI-1:0][63:0]     out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    generate
        for (genvar i = 0; i < NI; i++) begin : g_dut
            sbox_layer_dec #(.SIZE(64), .NPC(1 << i)) dut (
`ifdef SBOX_LAYER_FWD_EN
                .inverse   (inverse),
`endif
                .Clock     (Clock),
                .Reset_n   (Reset_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready[i]),
                .in_data   (in_data),
                .out_valid (out_valid[i]),
                .out_ready (out_ready),
                .out_data  (out_data[i]),
                .busy      (busy[i])
            );
        end
    endgenerate

    function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[4*k +: 4] = inv ? INV_T[d[4*k +: 4]] : FWD_T[d[4*k +: 4]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Transaction-level model: a word is pending from acceptance until it is
    // taken downstream; it becomes visible 16/NPC edges after acceptance.
    bit          pend [NI];
    int          acc  [NI];
    logic [63:0] expv [NI];

    always @(negedge Clock) begin
        for (int i = 0; i < NI; i++) begin
            if (!Reset_n) begin
                chk("rst in_ready", 64'(in_ready[i]), 64'd1);
                chk("rst out_valid", 64'(out_valid[i]), 64'd0);
                chk("rst busy", 64'(busy[i]), 64'd0);
                chk("rst out_data", out_data[i], 64'd0);
                pend[i] = 1'b0;
            end else begin
                bit ev;
                ev = pend[i] && (cyc >= acc[i] + (16 >> i));
                chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(!pend[i]));
                chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(pend[i]));
                chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(ev));
                if (ev) chk($sformatf("out_data[%0d]", i), out_data[i], expv[i]);
                if (!pend[i] && in_valid) begin
                    pend[i] = 1'b1;
                    acc[i]  = cyc + 1;
`ifdef SBOX_LAYER_FWD_EN
                    expv[i] = model(in_data, inverse);
`else
                    expv[i] = model(in_data, 1'b1);
`endif
                end else if (ev && out_ready) begin
                    pend[i] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_all_idle();
        int n;
        n = 0;
        while (!(&in_ready) && n < 100) begin
            tick();
            n++;
        end
        if (!(&in_ready)) begin
            checks++;
            errors++;
            $display("FAIL idle timeout actual=%b required=%b", in_ready, {NI{1'b1}});
        end
    endtask

    task automatic send(input logic [63:0] d);
        wait_all_idle();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Accept one word on all instances, then record per-instance latency and result.
    task automatic measure(input string nm, input logic [63:0] d, input logic [63:0] req);
        int          lat [NI];
        logic [63:0] got [NI];
        for (int i = 0; i < NI; i++) begin
            lat[i] = -1;
            got[i] = 'x;
        end
        send(d);
        for (int n = 1; n <= 40; n++) begin
            tick();
            for (int i = 0; i < NI; i++)
                if (out_valid[i] && lat[i] < 0) begin
                    lat[i] = n;
                    got[i] = out_data[i];
                end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s latency npc%0d", nm, 1 << i), 64'(lat[i]), 64'(16 >> i));
            chk($sformatf("%s data npc%0d", nm, 1 << i), got[i], req);
        end
    endtask

    initial begin
        // Literal pins on the model itself.
        chk("model inv 0123", model(64'h0123456789ABCDEF, 1'b1), 64'h5EF8C12DB463079A);
        chk("model inv zero", model(64'h0, 1'b1), 64'h5555555555555555);
        chk("model inv ones", model(64'hFFFFFFFFFFFFFFFF, 1'b1), 64'hAAAAAAAAAAAAAAAA);
        chk("model fwd zero", model(64'h0, 1'b0), 64'hCCCCCCCCCCCCCCCC);
        chk("model round trip", model(64'hCCCCCCCCCCCCCCCC, 1'b1), 64'h0);

        // Reset state.
        tick(); tick();
        chk("reset in_ready", 64'(in_ready), 64'h1F);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset out_data npc4", out_data[2], 64'h0);
        Reset_n = 1'b1;
        tick();

        // Single word, plus NPC sweep latency and result.
        out_ready = 1'b1;
        measure("basic", 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);

        // Backpressure: held result, no accept.
        out_ready = 1'b0;
        send(64'h0);
        repeat (30) tick();
        chk("bp out_valid", 64'(out_valid), 64'h1F);
        chk("bp in_ready", 64'(in_ready), 64'h0);
        chk("bp out_data npc4", out_data[2], 64'h5555555555555555);
        out_ready = 1'b1;
        tick();
        chk("bp release idle", 64'(in_ready), 64'h1F);
        chk("bp release out_valid", 64'(out_valid), 64'h0);

        // in_valid and changing in_data outside IDLE are ignored.
        out_ready = 1'b0;
        send(64'h0123456789ABCDEF);
        in_valid = 1'b1;
        in_data  = 64'hDEADBEEFCAFEF00D;
        repeat (20) tick();
        in_valid = 1'b0;
        chk("hold data npc4", out_data[2], 64'h5EF8C12DB463079A);
        chk("hold data npc1", out_data[0], 64'h5EF8C12DB463079A);
        out_ready = 1'b1;
        tick();
        tick();

        // Reset during the second RUN cycle aborts the word.
        send(64'h0123456789ABCDEF);
        tick();
        Reset_n = 1'b0;
        #2;
        chk("abort in_ready", 64'(in_ready), 64'h1F);
        chk("abort out_valid", 64'(out_valid), 64'h0);
        chk("abort busy", 64'(busy), 64'h0);
        chk("abort out_data npc4", out_data[2], 64'h0);
        tick();
        Reset_n = 1'b1;
        repeat (20) tick();
        chk("abort no output", 64'(out_valid), 64'h0);
        measure("after abort", 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA);

`ifdef SBOX_LAYER_FWD_EN
        inverse = 1'b0;
        measure("fwd", 64'h0, 64'hCCCCCCCCCCCCCCCC);
        inverse = 1'b1;
        measure("fwd back", 64'hCCCCCCCCCCCCCCCC, 64'h0);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
